// File: rtl/regfile_wb_arbiter.sv
// Two-port (ALU / load) writeback arbiter with a registered write port and busy-bit scoreboard.
// Define WB_ARB_FIXED_PRIO_EN to give the load port fixed priority instead of round-robin.
module regfile_wb_arbiter #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [ADDR_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0] alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [ADDR_WIDTH-1:0] mem_rd,
   input  logic [DATA_WIDTH-1:0] mem_data,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   input  logic [ADDR_WIDTH-1:0] read_addr1,
   input  logic [ADDR_WIDTH-1:0] read_addr2,
   input  logic                  flush,
   output logic                  write_enable,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic [31:0]           busy,
   output logic                  raw_stall
);

   logic                  gnt_alu, gnt_mem, xfer;
   logic [ADDR_WIDTH-1:0] win_rd;
   logic [DATA_WIDTH-1:0] win_data;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] wa_q;
   logic [DATA_WIDTH-1:0] wd_q;
   logic [31:0]           busy_q, busy_d;

`ifndef WB_ARB_FIXED_PRIO_EN
   // ptr_q = 1 means the mem port is favoured on the next contended cycle
   logic ptr_q;

   always_ff @(posedge clk) begin
      if (reset)
         ptr_q <= 1'b0;
      else if (xfer)
         ptr_q <= gnt_alu;
   end
`endif

   always_comb begin
      gnt_alu = 1'b0;
      gnt_mem = 1'b0;
      if (!reset && !flush) begin
         if (alu_valid && mem_valid) begin
`ifdef WB_ARB_FIXED_PRIO_EN
            gnt_mem = 1'b1;
`else
            gnt_mem = ptr_q;
            gnt_alu = !ptr_q;
`endif
         end else begin
            gnt_alu = alu_valid;
            gnt_mem = mem_valid;
         end
      end
   end

   assign alu_ready = gnt_alu;
   assign mem_ready = gnt_mem;
   assign xfer      = gnt_alu | gnt_mem;
   assign win_rd    = gnt_mem ? mem_rd   : alu_rd;
   assign win_data  = gnt_mem ? mem_data : alu_data;

   // rd=0 transfers are consumed but never reach the register file
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q <= 1'b0;
         wa_q <= '0;
         wd_q <= '0;
      end else begin
         we_q <= xfer && (win_rd != '0);
         if (xfer && (win_rd != '0)) begin
            wa_q <= win_rd;
            wd_q <= win_data;
         end
      end
   end

   always_comb begin
      busy_d = busy_q;
      if (we_q)
         busy_d[wa_q] = 1'b0;
      if (issue_valid && (issue_rd != '0))
         busy_d[issue_rd] = 1'b1;
      if (flush)
         busy_d = '0;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   assign write_enable = we_q;
   assign write_addr   = wa_q;
   assign write_data   = wd_q;
   assign busy         = busy_q;
   assign raw_stall    = !reset && (busy_q[read_addr1] || busy_q[read_addr2]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; expectations follow WB_ARB_FIXED_PRIO_EN.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd;
   logic [63:0] alu_data;
   logic        mem_valid, mem_ready;
   logic [4:0]  mem_rd;
   logic [63:0] mem_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  read_addr1, read_addr2;
   logic        flush;
   logic        write_enable;
   logic [4:0]  write_addr;
   logic [63:0] write_data;
   logic [31:0] busy;
   logic        raw_stall;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .read_addr1(read_addr1), .read_addr2(read_addr2), .flush(flush),
      .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
      .busy(busy), .raw_stall(raw_stall)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic exp_mem;

   initial begin
      reset = 1'b1; flush = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h1;
      mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'h2;
      issue_valid = 1'b0; issue_rd = '0; read_addr1 = '0; read_addr2 = '0;
      tick(); tick();
      check("rst_alu_ready", alu_ready, 0);
      check("rst_mem_ready", mem_ready, 0);
      check("rst_we", write_enable, 0);
      check("rst_waddr", write_addr, 0);
      check("rst_wdata", write_data, 0);
      check("rst_busy", busy, 0);
      check("rst_stall", raw_stall, 0);
      reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
      tick();

      // single ALU writeback
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h11;
      #1;
      check("alu_ready_single", alu_ready, 1);
      check("mem_ready_single", mem_ready, 0);
      tick();
      alu_valid = 1'b0;
      check("wb1_we", write_enable, 1);
      check("wb1_addr", write_addr, 5);
      check("wb1_data", write_data, 64'h11);
      tick();
      check("wb1_we_drop", write_enable, 0);

      // contention from a fresh pointer
      reset = 1'b1; tick(); reset = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hA3;
      mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 64'hB4;
      for (int i = 0; i < 4; i++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
         exp_mem = 1'b1;
`else
         exp_mem = (i % 2) == 1;
`endif
         #1;
         check("rr_alu_ready", alu_ready, !exp_mem);
         check("rr_mem_ready", mem_ready, exp_mem);
         tick();
         check("rr_we", write_enable, 1);
         check("rr_addr", write_addr, exp_mem ? 5'd4 : 5'd3);
         check("rr_data", write_data, exp_mem ? 64'hB4 : 64'hA3);
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      tick();
      check("rr_we_idle", write_enable, 0);

      // RAW stall on r7 until its writeback retires
      issue_valid = 1'b1; issue_rd = 5'd7;
      tick();
      issue_valid = 1'b0; read_addr1 = 5'd7;
      #1;
      check("raw_set", raw_stall, 1);
      check("busy7", busy, 32'h80);
      tick(); tick();
      check("raw_hold", raw_stall, 1);
      mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'h77;
      #1;
      check("mem_only_ready", mem_ready, 1);
      tick();
      mem_valid = 1'b0;
      check("raw_wb_we", write_enable, 1);
      check("raw_wb_addr", write_addr, 7);
      check("raw_during_wb", raw_stall, 1);
      tick();
      check("raw_clear", raw_stall, 0);
      read_addr1 = '0;

      // set beats same-edge clear on r9
      issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      issue_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
      tick();
      alu_valid = 1'b0;
      check("r9_we", write_enable, 1);
      issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      issue_valid = 1'b0;
      check("set_wins", busy, 32'h200);

      // flush with a write pending
      issue_valid = 1'b1; issue_rd = 5'd3; tick();
      issue_rd = 5'd8; tick();
      issue_valid = 1'b0;
      check("pre_flush_busy", busy, 32'h308);
      alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 64'hCC;
      tick();
      alu_rd = 5'd13; alu_data = 64'hDD;
      mem_valid = 1'b1; mem_rd = 5'd14;
      flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd15;
      #1;
      check("flush_alu_ready", alu_ready, 0);
      check("flush_mem_ready", mem_ready, 0);
      check("flush_pending_we", write_enable, 1);
      check("flush_pending_addr", write_addr, 12);
      check("flush_pending_data", write_data, 64'hCC);
      tick();
      flush = 1'b0; issue_valid = 1'b0; mem_valid = 1'b0;
      check("flush_busy", busy, 0);
      check("flush_we_drop", write_enable, 0);
      #1;
      check("post_flush_ready", alu_ready, 1);
      tick();
      alu_valid = 1'b0;
      check("post_flush_addr", write_addr, 13);

      // rd=0 transfer is accepted but silent; issue to r0 ignored
      issue_valid = 1'b1; issue_rd = 5'd6; tick();
      issue_rd = 5'd0;
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hDEAD;
      #1;
      check("rd0_ready", alu_ready, 1);
      tick();
      alu_valid = 1'b0; issue_valid = 1'b0;
      check("rd0_we", write_enable, 0);
      check("rd0_busy", busy, 32'h40);

      // reset aborts a registered write
      alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 64'h20;
      tick();
      alu_valid = 1'b0;
      check("abort_pending", write_enable, 1);
      read_addr2 = 5'd6; reset = 1'b1;
      #1;
      check("rst_gates_stall", raw_stall, 0);
      tick();
      check("abort_we", write_enable, 0);
      check("abort_addr", write_addr, 0);
      check("abort_busy", busy, 0);
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
